// File: rtl/riscv_hwlp_pkg.sv
// rtl/riscv_hwlp_pkg.sv - shared types and constants for the hardware-loop sequencer
package riscv_hwlp_pkg;

    typedef enum logic [1:0] {
        HWLP_IDLE,
        HWLP_CHAIN,
        HWLP_JUMP
    } hwlp_seq_state_e;

    localparam logic [31:0] HWLP_CNT_LAST = 32'd1;

endpackage

// File: rtl/riscv_hwlp_match.sv
// rtl/riscv_hwlp_match.sv - finds the lowest active loop at or above i_start whose end address equals the PC
module riscv_hwlp_match
    import riscv_hwlp_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic [31:0]          i_pc,
    input  logic [N_REGS*32-1:0] i_end_addr,
    input  logic [N_REGS*32-1:0] i_counter,
    input  logic [N_REGS-1:0]    i_eligible,
    input  logic [N_REG_BITS:0]  i_start,
    output logic                 o_found,
    output logic [N_REG_BITS-1:0] o_idx,
    output logic                 o_last
);

    // Scanning from the top down lets the lowest matching index win.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        o_last  = 1'b0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if ((k >= int'(i_start)) && i_eligible[k] &&
                (i_counter[k*32 +: 32] != 32'd0) &&
                (i_pc == i_end_addr[k*32 +: 32])) begin
                o_found = 1'b1;
                o_idx   = N_REG_BITS'(k);
                o_last  = (i_counter[k*32 +: 32] == HWLP_CNT_LAST);
            end
        end
    end

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// rtl/riscv_hwloop_sequencer.sv - ID-stage hardware-loop sequencer: decrement strobes, chaining and jump request
module riscv_hwloop_sequencer
    import riscv_hwlp_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           id_pc_i,
    input  logic                  id_valid_i,
    input  logic                  flush_i,
    input  logic [N_REGS*32-1:0]  hwlp_start_addr_i,
    input  logic [N_REGS*32-1:0]  hwlp_end_addr_i,
    input  logic [N_REGS*32-1:0]  hwlp_counter_i,
    input  logic                  hwlp_cnt_we_i,
    input  logic [N_REG_BITS-1:0] hwlp_regid_i,
    output logic [N_REGS-1:0]     hwlp_dec_cnt_o,
    output logic                  stall_o,
    output logic                  jump_req_o,
    output logic [31:0]           jump_target_o,
    input  logic                  jump_ack_i
);

    hwlp_seq_state_e       r_state;
    logic [N_REG_BITS-1:0] r_idx;
    logic [31:0]           r_target;
    logic                  r_jump_req;
    logic                  r_stall;

    logic [N_REGS-1:0]     w_eligible;
    logic [N_REG_BITS:0]   w_start_a;
    logic [N_REG_BITS:0]   w_start_b;
    logic                  w_found_a;
    logic                  w_last_a;
    logic [N_REG_BITS-1:0] w_idx_a;
    logic                  w_found_b;
    logic                  w_unused_last_b;
    logic [N_REG_BITS-1:0] w_idx_b;
    logic                  w_in_chain;
    logic                  w_dec_en;
    logic                  w_advance;

    // A counter write to a set wins in the register file, so that set cannot take a decrement.
    always_comb begin
        w_eligible = '1;
        for (int k = 0; k < N_REGS; k++) begin
            if (hwlp_cnt_we_i && (hwlp_regid_i == N_REG_BITS'(k))) begin
                w_eligible[k] = 1'b0;
            end
        end
    end

    assign w_in_chain = (r_state == HWLP_CHAIN);
    assign w_start_a  = w_in_chain ? {1'b0, r_idx} : '0;
    assign w_start_b  = {1'b0, w_idx_a} + {{N_REG_BITS{1'b0}}, 1'b1};

    riscv_hwlp_match #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_match_sel (
        .i_pc       (id_pc_i),
        .i_end_addr (hwlp_end_addr_i),
        .i_counter  (hwlp_counter_i),
        .i_eligible (w_eligible),
        .i_start    (w_start_a),
        .o_found    (w_found_a),
        .o_idx      (w_idx_a),
        .o_last     (w_last_a)
    );

    riscv_hwlp_match #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_match_outer (
        .i_pc       (id_pc_i),
        .i_end_addr (hwlp_end_addr_i),
        .i_counter  (hwlp_counter_i),
        .i_eligible (w_eligible),
        .i_start    (w_start_b),
        .o_found    (w_found_b),
        .o_idx      (w_idx_b),
        .o_last     (w_unused_last_b)
    );

    // In CHAIN the strobe is held regardless of valid; the register file only acts when valid is seen.
    assign w_dec_en  = !flush_i && w_found_a &&
                       (w_in_chain || ((r_state == HWLP_IDLE) && id_valid_i));
    assign w_advance = w_dec_en && id_valid_i;

    always_comb begin
        hwlp_dec_cnt_o = '0;
        if (w_dec_en) begin
            hwlp_dec_cnt_o[w_idx_a] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= HWLP_IDLE;
            r_idx      <= '0;
            r_target   <= 32'd0;
            r_jump_req <= 1'b0;
            r_stall    <= 1'b0;
        end else if (flush_i) begin
            r_state    <= HWLP_IDLE;
            r_jump_req <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            case (r_state)
                HWLP_IDLE, HWLP_CHAIN: begin
                    if (w_advance) begin
                        if (!w_last_a) begin
                            r_target   <= hwlp_start_addr_i[w_idx_a*32 +: 32];
                            r_state    <= HWLP_JUMP;
                            r_jump_req <= 1'b1;
                            r_stall    <= 1'b0;
                        end else if (w_found_b) begin
                            r_idx      <= w_idx_b;
                            r_state    <= HWLP_CHAIN;
                            r_stall    <= 1'b1;
                        end else begin
                            r_state    <= HWLP_IDLE;
                            r_stall    <= 1'b0;
                        end
                    end else if (w_in_chain && !w_found_a) begin
                        r_state <= HWLP_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                HWLP_JUMP: begin
                    if (jump_ack_i) begin
                        r_state    <= HWLP_IDLE;
                        r_jump_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= HWLP_IDLE;
                    r_jump_req <= 1'b0;
                    r_stall    <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o       = r_stall;
    assign jump_req_o    = r_jump_req;
    assign jump_target_o = r_target;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($countones(hwlp_dec_cnt_o) <= 1);
        end
    end

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// tb/tb_riscv_hwloop_sequencer.sv - self-checking bench for riscv_hwloop_sequencer
module tb_riscv_hwloop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_pc_i;
    logic        id_valid_i;
    logic        flush_i;
    logic [63:0] hwlp_start_addr_i;
    logic [63:0] hwlp_end_addr_i;
    logic [63:0] hwlp_counter_i;
    logic        hwlp_cnt_we_i;
    logic [0:0]  hwlp_regid_i;
    logic [1:0]  hwlp_dec_cnt_o;
    logic        stall_o;
    logic        jump_req_o;
    logic [31:0] jump_target_o;
    logic        jump_ack_i;

    logic [31:0] st [2];
    logic [31:0] en [2];
    logic [31:0] cnt [2];
    logic [31:0] mcnt [2];
    logic [31:0] wval;
    int errs = 0;
    int checks = 0;
    int dec_total = 0;

    assign hwlp_start_addr_i = {st[1], st[0]};
    assign hwlp_end_addr_i   = {en[1], en[0]};
    assign hwlp_counter_i    = {cnt[1], cnt[0]};

    always #5 clk = ~clk;

    riscv_hwloop_sequencer #(.N_REGS(2), .N_REG_BITS(1)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_pc_i           (id_pc_i),
        .id_valid_i        (id_valid_i),
        .flush_i           (flush_i),
        .hwlp_start_addr_i (hwlp_start_addr_i),
        .hwlp_end_addr_i   (hwlp_end_addr_i),
        .hwlp_counter_i    (hwlp_counter_i),
        .hwlp_cnt_we_i     (hwlp_cnt_we_i),
        .hwlp_regid_i      (hwlp_regid_i),
        .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
        .stall_o           (stall_o),
        .jump_req_o        (jump_req_o),
        .jump_target_o     (jump_target_o),
        .jump_ack_i        (jump_ack_i)
    );

    // Drive inputs just after a rising edge, then wait to the falling edge for sampling.
    task automatic apply(input logic [31:0] pc, input logic v, input logic f, input logic we,
                         input logic rid, input logic [31:0] wv, input logic ack);
        id_pc_i = pc; id_valid_i = v; flush_i = f; hwlp_cnt_we_i = we;
        hwlp_regid_i = rid; wval = wv; jump_ack_i = ack;
        @(negedge clk);
    endtask

    // Register file: decrement on strobe+valid, a write wins.
    task automatic tick();
        logic [1:0] d;
        d = hwlp_dec_cnt_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (id_valid_i && d[k]) begin
                cnt[k] = cnt[k] - 32'd1;
                dec_total++;
            end
        end
        if (hwlp_cnt_we_i) cnt[hwlp_regid_i] = wval;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st[0] = 0; st[1] = 0; en[0] = 0; en[1] = 0; cnt[0] = 0; cnt[1] = 0;
        apply(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b00) begin errs++; $display("FAIL reset_dec: got %b want 00", hwlp_dec_cnt_o); end
        checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        checks++; if (jump_req_o !== 1'b0) begin errs++; $display("FAIL reset_jump: got %b want 0", jump_req_o); end
        checks++; if (jump_target_o !== 32'h0) begin errs++; $display("FAIL reset_target: got %h want 0", jump_target_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_jump();
        st[0] = 32'h100; en[0] = 32'h10C; cnt[0] = 3; en[1] = 32'h500; cnt[1] = 0;
        apply(32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b01) begin errs++; $display("FAIL jump_dec: got %b want 01", hwlp_dec_cnt_o); end
        checks++; if (jump_req_o !== 1'b0) begin errs++; $display("FAIL jump_req_early: got %b want 0", jump_req_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, (i == 2));
            checks++; if (jump_req_o !== 1'b1) begin errs++; $display("FAIL jump_req_held%0d: got %b want 1", i, jump_req_o); end
            checks++; if (jump_target_o !== 32'h100) begin errs++; $display("FAIL jump_target%0d: got %h want 100", i, jump_target_o); end
            checks++; if (hwlp_dec_cnt_o !== 2'b00) begin errs++; $display("FAIL jump_dec_in_jump%0d: got %b want 00", i, hwlp_dec_cnt_o); end
            tick();
        end
        apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (jump_req_o !== 1'b0) begin errs++; $display("FAIL jump_req_after_ack: got %b want 0", jump_req_o); end
        checks++; if (cnt[0] !== 32'd2) begin errs++; $display("FAIL jump_cnt0: got %0d want 2", cnt[0]); end
        tick();
    endtask

    task automatic test_last();
        cnt[0] = 1; cnt[1] = 0;
        apply(32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b01) begin errs++; $display("FAIL last_dec: got %b want 01", hwlp_dec_cnt_o); end
        tick();
        apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (jump_req_o !== 1'b0) begin errs++; $display("FAIL last_jump: got %b want 0", jump_req_o); end
        checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL last_stall: got %b want 0", stall_o); end
        checks++; if (cnt[0] !== 32'd0) begin errs++; $display("FAIL last_cnt0: got %0d want 0", cnt[0]); end
        tick();
    endtask

    task automatic test_chain();
        int d0;
        en[0] = 32'h200; en[1] = 32'h200; st[1] = 32'h180; cnt[0] = 1; cnt[1] = 4;
        d0 = dec_total;
        apply(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b01) begin errs++; $display("FAIL chain_dec_t0: got %b want 01", hwlp_dec_cnt_o); end
        tick();
        apply(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (stall_o !== 1'b1) begin errs++; $display("FAIL chain_stall_t1: got %b want 1", stall_o); end
        checks++; if (hwlp_dec_cnt_o !== 2'b10) begin errs++; $display("FAIL chain_dec_t1: got %b want 10", hwlp_dec_cnt_o); end
        tick();
        apply(32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (jump_req_o !== 1'b1) begin errs++; $display("FAIL chain_jump_t2: got %b want 1", jump_req_o); end
        checks++; if (jump_target_o !== 32'h180) begin errs++; $display("FAIL chain_target: got %h want 180", jump_target_o); end
        checks++; if (stall_o !== 1'b0) begin errs++; $display("FAIL chain_stall_t2: got %b want 0", stall_o); end
        checks++; if (dec_total - d0 !== 2) begin errs++; $display("FAIL chain_dec_count: got %0d want 2", dec_total - d0); end
        checks++; if (cnt[1] !== 32'd3) begin errs++; $display("FAIL chain_cnt1: got %0d want 3", cnt[1]); end
        tick();
        // Both loops on their last iteration, with a bubble while stalled.
        cnt[0] = 1; cnt[1] = 1;
        apply(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        apply(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (stall_o !== 1'b1) begin errs++; $display("FAIL chain_hold_stall: got %b want 1", stall_o); end
        tick();
        apply(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (stall_o !== 1'b1) begin errs++; $display("FAIL chain_hold_stall2: got %b want 1", stall_o); end
        checks++; if (hwlp_dec_cnt_o !== 2'b10) begin errs++; $display("FAIL chain_hold_dec: got %b want 10", hwlp_dec_cnt_o); end
        tick();
        apply(32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if ({stall_o, jump_req_o} !== 2'b00) begin errs++; $display("FAIL chain_fallthrough: got %b want 00", {stall_o, jump_req_o}); end
        checks++; if ({cnt[1], cnt[0]} !== 64'h0) begin errs++; $display("FAIL chain_cnts: got %h want 0", {cnt[1], cnt[0]}); end
        tick();
    endtask

    task automatic test_mask();
        st[0] = 32'h100; en[0] = 32'h10C; cnt[0] = 3; cnt[1] = 0;
        apply(32'h10C, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b00) begin errs++; $display("FAIL mask_dec: got %b want 00", hwlp_dec_cnt_o); end
        tick();
        apply(32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (jump_req_o !== 1'b0) begin errs++; $display("FAIL mask_jump: got %b want 0", jump_req_o); end
        tick();
        apply(32'h10C, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b01) begin errs++; $display("FAIL mask_other_dec: got %b want 01", hwlp_dec_cnt_o); end
        tick();
        apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if ({jump_req_o, jump_target_o} !== {1'b1, 32'h100}) begin errs++; $display("FAIL mask_other_jump: got %b/%h want 1/100", jump_req_o, jump_target_o); end
        checks++; if (cnt[0] !== 32'd4) begin errs++; $display("FAIL mask_cnt0: got %0d want 4", cnt[0]); end
        tick();
    endtask

    task automatic test_flush();
        st[0] = 32'h100; en[0] = 32'h10C; cnt[0] = 3; cnt[1] = 0;
        apply(32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if (jump_req_o !== 1'b1) begin errs++; $display("FAIL flush_pre%0d: got %b want 1", i, jump_req_o); end
            tick();
        end
        apply(32'h110, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (jump_req_o !== 1'b0) begin errs++; $display("FAIL flush_jump: got %b want 0", jump_req_o); end
        tick();
        apply(32'h10C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (hwlp_dec_cnt_o !== 2'b00) begin errs++; $display("FAIL flush_idle_dec: got %b want 00", hwlp_dec_cnt_o); end
        tick();
        apply(32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if ({jump_req_o, cnt[0]} !== {1'b0, 32'd2}) begin errs++; $display("FAIL flush_idle_state: got %b/%0d want 0/2", jump_req_o, cnt[0]); end
        tick();
        // Asynchronous reset while in CHAIN.
        en[0] = 32'h200; en[1] = 32'h200; st[1] = 32'h180; cnt[0] = 1; cnt[1] = 4;
        apply(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        id_valid_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b1) begin errs++; $display("FAIL rst_pre_stall: got %b want 1", stall_o); end
        rst = 1'b1;
        #1;
        checks++; if ({hwlp_dec_cnt_o, stall_o, jump_req_o, jump_target_o} !== 36'h0) begin
            errs++; $display("FAIL rst_async: got %b %b %b %h want all 0", hwlp_dec_cnt_o, stall_o, jump_req_o, jump_target_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] pcs [3] = '{32'h200, 32'h300, 32'h204};
        logic        mj = 1'b0;
        logic [31:0] mtgt = 32'h0;
        int          mchain = -1;
        int          mdec_total = dec_total;
        mcnt[0] = cnt[0]; mcnt[1] = cnt[1];
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] pc;
            logic [31:0] wv;
            logic v, f, we, rid, ack;
            logic [1:0] act;
            logic [1:0] ed;
            int sel;
            int nxt;
            if (mchain < 0) begin
                if ($urandom_range(15) == 0) en[$urandom_range(1)] = ($urandom_range(1) == 1) ? 32'h200 : 32'h300;
                if ($urandom_range(15) == 0) st[$urandom_range(1)] = $urandom & 32'hFFFC;
                pc = pcs[$urandom_range(2)];
                we = ($urandom_range(3) == 0);
            end else begin
                pc = id_pc_i;
                we = 1'b0;
            end
            v   = ($urandom_range(3) != 0);
            f   = ($urandom_range(15) == 0);
            rid = 1'($urandom_range(1));
            ack = 1'($urandom_range(1));
            wv  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(3));
            for (int k = 0; k < 2; k++)
                act[k] = (mcnt[k] != 0) && !(we && int'(rid) == k) && (pc == en[k]);
            ed = 2'b00;
            sel = -1;
            if (!mj) begin
                if (mchain >= 0) begin
                    if (!f) ed[mchain] = 1'b1;
                end else begin
                    sel = act[0] ? 0 : (act[1] ? 1 : -1);
                    if (sel >= 0 && v && !f) ed[sel] = 1'b1;
                end
            end
            apply(pc, v, f, we, rid, wv, ack);
            checks++; if (hwlp_dec_cnt_o !== ed) begin errs++; $display("FAIL rnd_dec c=%0d: got %b want %b", c, hwlp_dec_cnt_o, ed); end
            checks++; if (jump_req_o !== mj) begin errs++; $display("FAIL rnd_jump c=%0d: got %b want %b", c, jump_req_o, mj); end
            checks++; if (stall_o !== (mchain >= 0)) begin errs++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall_o, (mchain >= 0)); end
            checks++; if ($countones(hwlp_dec_cnt_o) > 1) begin errs++; $display("FAIL rnd_onehot c=%0d: got %b want onehot0", c, hwlp_dec_cnt_o); end
            if (mj) begin
                checks++; if (jump_target_o !== mtgt) begin errs++; $display("FAIL rnd_target c=%0d: got %h want %h", c, jump_target_o, mtgt); end
            end
            if (f) begin
                mj = 1'b0; mchain = -1;
            end else if (mj) begin
                if (ack) mj = 1'b0;
            end else if (ed != 2'b00 && v) begin
                sel = ed[1] ? 1 : 0;
                if (mcnt[sel] != 32'd1) begin
                    mj = 1'b1; mtgt = st[sel]; mchain = -1;
                end else begin
                    nxt = -1;
                    for (int k = 1; k >= 0; k--) if (k > sel && act[k]) nxt = k;
                    mchain = nxt;
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (v && ed[k]) begin
                    mcnt[k] = mcnt[k] - 32'd1;
                    mdec_total++;
                end
            end
            if (we) mcnt[rid] = wv;
        end
        checks++; if (cnt[0] !== mcnt[0]) begin errs++; $display("FAIL rnd_cnt0: got %h want %h", cnt[0], mcnt[0]); end
        checks++; if (cnt[1] !== mcnt[1]) begin errs++; $display("FAIL rnd_cnt1: got %h want %h", cnt[1], mcnt[1]); end
        checks++; if (dec_total !== mdec_total) begin errs++; $display("FAIL rnd_dec_total: got %0d want %0d", dec_total, mdec_total); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_last();
        test_chain();
        test_mask();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
